// File: rtl/spi_poll_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : spi_poll_ctrl_if
// Brief    : Bus bundle between the poll controller, the byte-read SPI master
//            and the downstream byte consumer.
//            master modport = the poll controller, slave modport = its peers.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface spi_poll_ctrl_if;
  logic       spi_start;
  logic       spi_done;
  logic [7:0] spi_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output spi_start,
    input  spi_done,
    input  spi_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  spi_start,
    output spi_done,
    output spi_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/spi_poll_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : spi_poll_ctrl
// Brief    : Periodically starts a byte-read SPI transaction, captures each
//            received byte into a first-word fall-through FIFO, counts
//            dropped bytes (saturating) and optionally flags transactions
//            that never complete.
// Options  : SPI_POLL_TIMEOUT_EN - enables the WAIT-state timeout and the
//            sticky timeout_err flag (otherwise timeout_err is tied low).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module spi_poll_ctrl #(
  parameter int POLL_DIV   = 1000,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        enable,
  spi_poll_ctrl_if.master  bus,
  output logic             busy,
  output logic [7:0]       overflow_cnt,
  output logic             timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(POLL_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_req;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          fifo_empty, fifo_full, fifo_pop, fifo_push;

`ifdef SPI_POLL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          terr_q, terr_d;
`endif

  // Poll FSM: interval countdown in IDLE, one-cycle START, WAIT for done
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
`ifdef SPI_POLL_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    terr_d     = terr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef SPI_POLL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.spi_done) begin
          // A completion in the final timeout cycle still wins.
          push_req = 1'b1;
          cnt_d    = RELOAD;
          state_d  = ST_IDLE;
`ifdef SPI_POLL_TIMEOUT_EN
        end else if (wait_cnt_q == WAIT_LAST) begin
          terr_d  = 1'b1;
          cnt_d   = RELOAD;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = RELOAD;
      end
    endcase
  end

  // FIFO pointer and drop-counter next-state; a pop frees room for a push
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    fifo_pop   = !fifo_empty && bus.out_ready;
    fifo_push  = push_req && (!fifo_full || fifo_pop);
    wr_ptr_d   = fifo_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = fifo_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    ovf_d      = ovf_q;
    if (push_req && fifo_full && !fifo_pop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= RELOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
`ifdef SPI_POLL_TIMEOUT_EN
      wait_cnt_q <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
`ifdef SPI_POLL_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      terr_q     <= terr_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since out_valid gates them
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.spi_data;
    end
  end

  assign bus.spi_start = (state_q == ST_START);
  assign busy          = (state_q == ST_START) || (state_q == ST_WAIT);
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_cnt  = ovf_q;
`ifdef SPI_POLL_TIMEOUT_EN
  assign timeout_err   = terr_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_poll_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_spi_poll_ctrl
// Brief    : Directed self-checking bench for spi_poll_ctrl (POLL_DIV=4,
//            FIFO_DEPTH=8, TIMEOUT=32). Inputs change and outputs are
//            sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_spi_poll_ctrl;

  localparam int POLL_DIV   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       busy;
  logic [7:0] overflow_cnt;
  logic       timeout_err;

  int vec  = 0;
  int errs = 0;

  spi_poll_ctrl_if bus_if ();

  spi_poll_ctrl #(
    .POLL_DIV  (POLL_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus_if),
    .busy        (busy),
    .overflow_cnt(overflow_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    enable           = 1'b0;
    bus_if.spi_done  = 1'b0;
    bus_if.spi_data  = 8'h00;
    bus_if.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Count falling edges until spi_start is seen; bounded
  task automatic wait_start(output int n);
    n = 0;
    while (bus_if.spi_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus_if.spi_start !== 1'b1) begin
      vec++; errs++;
      $display("FAIL wait_start: spi_start=%b after %0d cycles, required 1", bus_if.spi_start, n);
    end
  endtask

  // One transaction: master answers dly cycles after the spi_start cycle
  task automatic poll(input logic [7:0] b, input int dly);
    int n;
    wait_start(n);
    repeat (dly) tick();
    bus_if.spi_done = 1'b1;
    bus_if.spi_data = b;
    tick();
    bus_if.spi_done = 1'b0;
    bus_if.spi_data = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (bus_if.spi_start !== 1'b0) begin errs++; $display("FAIL reset_spi_start: got %b want 0", bus_if.spi_start); end
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (overflow_cnt !== 8'd0) begin errs++; $display("FAIL reset_overflow: got %0d want 0", overflow_cnt); end
    vec++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_first_poll();
    int n;
    do_reset();
    enable           = 1'b1;
    bus_if.out_ready = 1'b1;
    wait_start(n);
    vec++; if (n != 4) begin errs++; $display("FAIL first_start_cycle: got %0d want 4", n); end
    tick();
    vec++; if (bus_if.spi_start !== 1'b0) begin errs++; $display("FAIL start_pulse_width: spi_start=%b want 0", bus_if.spi_start); end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_in_wait: got %b want 1", busy); end
    repeat (9) tick();
    bus_if.spi_done = 1'b1;
    bus_if.spi_data = 8'hA5;
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL no_bypass: out_valid=%b want 0", bus_if.out_valid); end
    tick();
    bus_if.spi_done = 1'b0;
    vec++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'hA5) begin
      errs++; $display("FAIL first_byte: valid=%b data=%h want 1/a5", bus_if.out_valid, bus_if.out_data);
    end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL busy_idle: got %b want 0", busy); end
    tick();
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL pop_empty: out_valid=%b want 0", bus_if.out_valid); end
    // IDLE cycles S+11..S+14, next START at S+15; this is S+12
    wait_start(n);
    vec++; if (n != 3) begin errs++; $display("FAIL second_start_cycle: got %0d want 3", n); end
    enable = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) poll(8'(i), 10);
    enable = 1'b0;
    vec++; if (overflow_cnt !== 8'd2) begin errs++; $display("FAIL overflow_count: got %0d want 2", overflow_cnt); end
    bus_if.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vec++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 8'(i)) begin
        errs++; $display("FAIL drain_%0d: valid=%b data=%h want 1/%h", i, bus_if.out_valid, bus_if.out_data, 8'(i));
      end
      tick();
    end
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty: out_valid=%b want 0", bus_if.out_valid); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    int n;
    logic [7:0] exp_q [$];
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      poll(8'h10 + 8'(i), 10);
      if (i > 0) exp_q.push_back(8'h10 + 8'(i));
    end
    exp_q.push_back(8'h55);
    wait_start(n);
    repeat (10) tick();
    bus_if.spi_done  = 1'b1;
    bus_if.spi_data  = 8'h55;
    bus_if.out_ready = 1'b1;
    vec++; if (bus_if.out_data !== 8'h10) begin errs++; $display("FAIL full_head: got %h want 10", bus_if.out_data); end
    tick();
    bus_if.spi_done  = 1'b0;
    bus_if.out_ready = 1'b0;
    enable           = 1'b0;
    vec++; if (overflow_cnt !== 8'd0) begin errs++; $display("FAIL full_pop_overflow: got %0d want 0", overflow_cnt); end
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vec++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp_q[i]) begin
        errs++; $display("FAIL full_pop_drain_%0d: valid=%b data=%h want 1/%h", i, bus_if.out_valid, bus_if.out_data, exp_q[i]);
      end
      tick();
    end
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL full_pop_empty: out_valid=%b want 0", bus_if.out_valid); end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 8 + 255; i++) poll(8'(i), 1);
    vec++; if (overflow_cnt !== 8'd255) begin errs++; $display("FAIL overflow_255: got %0d want 255", overflow_cnt); end
    for (int i = 0; i < 45; i++) poll(8'(i), 1);
    enable = 1'b0;
    vec++; if (overflow_cnt !== 8'd255) begin errs++; $display("FAIL overflow_saturate: got %0d want 255", overflow_cnt); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    enable = 1'b1;
    wait_start(n);
`ifdef SPI_POLL_TIMEOUT_EN
    // WAIT occupies S+1..S+32; abort after the 32nd WAIT cycle
    repeat (32) tick();
    vec++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errs++; $display("FAIL timeout_last_wait: busy=%b terr=%b want 1/0", busy, timeout_err);
    end
    tick();
    vec++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL timeout_flag: terr=%b busy=%b want 1/0", timeout_err, busy);
    end
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL timeout_fifo: out_valid=%b want 0", bus_if.out_valid); end
    wait_start(n);
    vec++; if (n != 4) begin errs++; $display("FAIL timeout_repoll: got %0d want 4", n); end
    repeat (10) tick();
    bus_if.spi_done = 1'b1;
    bus_if.spi_data = 8'h77;
    tick();
    bus_if.spi_done = 1'b0;
    vec++; if (timeout_err !== 1'b1 || bus_if.out_data !== 8'h77) begin
      errs++; $display("FAIL timeout_sticky: terr=%b data=%h want 1/77", timeout_err, bus_if.out_data);
    end
`else
    repeat (100) tick();
    vec++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errs++; $display("FAIL no_timeout: busy=%b terr=%b want 1/0", busy, timeout_err);
    end
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL no_timeout_fifo: out_valid=%b want 0", bus_if.out_valid); end
`endif
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    do_reset();
    enable = 1'b1;
    poll(8'h3C, 10);
    wait_start(n);
    repeat (5) tick();
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    rst             = 1'b0;
    bus_if.spi_done = 1'b1;
    bus_if.spi_data = 8'hFF;
    tick();
    bus_if.spi_done = 1'b0;
    bus_if.spi_data = 8'h00;
    tick();
    vec++; if (bus_if.out_valid !== 1'b0) begin errs++; $display("FAIL rst_wait_fifo: out_valid=%b data=%h want 0", bus_if.out_valid, bus_if.out_data); end
    vec++; if (busy !== 1'b0 || bus_if.spi_start !== 1'b0) begin
      errs++; $display("FAIL rst_wait_fsm: busy=%b start=%b want 0/0", busy, bus_if.spi_start);
    end
    vec++; if (overflow_cnt !== 8'd0 || timeout_err !== 1'b0) begin
      errs++; $display("FAIL rst_wait_status: ovf=%0d terr=%b want 0/0", overflow_cnt, timeout_err);
    end
    enable = 1'b1;
    wait_start(n);
    vec++; if (n != POLL_DIV) begin errs++; $display("FAIL rst_wait_restart: got %0d want %0d", n, POLL_DIV); end
    enable = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    enable           = 1'b0;
    bus_if.spi_done  = 1'b0;
    bus_if.spi_data  = 8'h00;
    bus_if.out_ready = 1'b0;
    tick();
    test_reset();
    test_first_poll();
    test_overflow();
    test_full_pop();
    test_saturate();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_poll_ctrl.md
Name: spi_poll_ctrl

Overview:
- Drives the `start` input of the byte-read SPI master at a fixed programmable interval.
- Captures each received byte when the master pulses `done`, and buffers it in a small FIFO with a valid/ready output toward the traffic-processing logic.
- Sits between the SPI master (`start`, `done`, `data_received`) and the downstream consumer.
- Reports dropped samples and, optionally, missing-completion timeouts.

Parameters:
- POLL_DIV, 1000: clk cycles from re-entering IDLE to the next `spi_start` pulse; must be ≥ 2.
- FIFO_DEPTH, 8: byte entries in the output FIFO; power of 2, ≥ 2.
- TIMEOUT, 32: max cycles spent in WAIT before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock, also the SPI master's clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  polling enable
- spi_start  out  1  one-cycle start pulse to the SPI master
- spi_done  in  1  one-cycle completion pulse from the SPI master
- spi_data  in  8  received byte; valid when spi_done=1
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in START or WAIT
- overflow_cnt  out  8  dropped-byte counter, saturating
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE, interval counter=POLL_DIV-1, FIFO emptied.
  - spi_start=0, out_valid=0, busy=0, overflow_cnt=0, timeout_err=0.
  - out_data is undefined while out_valid=0.
- Reset has priority over all other activity, including mid-WAIT. An spi_done arriving after reset while in IDLE is ignored.
- IDLE:
  - If enable=0, the counter reloads to POLL_DIV-1.
  - If enable=1 and counter≠0, the counter decrements by 1.
  - If enable=1 and counter=0, go to START.
  - Result: first spi_start is asserted in the cycle after POLL_DIV consecutive enabled IDLE cycles.
- START:
  - spi_start=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - On spi_done=1, push spi_data into the FIFO (subject to the full rules), reload the counter to POLL_DIV-1, and return to IDLE.
  - The SPI master's nominal completion is 10 cycles after the spi_start cycle.
- spi_done outside WAIT is ignored.
- Deasserting enable during START/WAIT does not abort the current transaction. Only IDLE checks enable.
- busy = (state==START || state==WAIT).
- FIFO:
  - First-word fall-through; out_valid = not empty; out_data = head entry, combinational from storage.
  - Pop when out_valid && out_ready. The next entry appears the following cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full = MSBs differ and the lower bits are equal.
  - Push while full and no pop in the same cycle: byte dropped; overflow_cnt increments, saturating at 255.
  - Push while full with a simultaneous pop: push accepted, count unchanged, no overflow.
  - Push and pop while empty: byte is written; out_valid rises next cycle. No bypass of the empty FIFO.

Optional Feature:
- Macro SPI_POLL_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter starts at 0 on entry and increments each cycle in WAIT.
  - If it reaches TIMEOUT-1 without spi_done, the block sets timeout_err=1 (sticky until rst), reloads the interval counter, and returns to IDLE. Nothing is pushed.
  - If spi_done arrives in that same final cycle, the byte is pushed and no timeout is flagged.
- Undefined: WAIT lasts indefinitely until spi_done; timeout_err is tied to 0; the WAIT counter logic is absent.

Test Plan:
- POLL_DIV=4, enable high from cycle 0 after reset, model master returns 0xA5 ten cycles after start, out_ready=1 → spi_start pulses exactly 1 cycle at cycle 4; out_valid=1 with out_data=0xA5 one cycle after spi_done; next spi_start occurs 4 IDLE cycles after the WAIT→IDLE transition.
- out_ready=0, FIFO_DEPTH=8, 10 polls returning 0x01..0x0A → 8 bytes held; overflow_cnt=2; draining yields 0x01..0x08 in order, then out_valid=0.
- FIFO full; spi_done (0x55) in the same cycle as a pop → overflow_cnt unchanged; 0x55 emerges as the last byte after draining.
- Force 300 drops → overflow_cnt saturates at 255.
- SPI_POLL_TIMEOUT_EN defined, TIMEOUT=32, master never responds → timeout_err=1 after 32 WAIT cycles; FIFO empty; polling continues. Without the macro: busy stays 1 and timeout_err=0.
- rst asserted mid-WAIT, then a late spi_done with 0xFF → all outputs at reset values; 0xFF not stored; first new spi_start POLL_DIV cycles after enable is sampled high.
